// File: rtl/cola_escritura_banco.sv
// Write-back queue for the 32x32 register bank: buffers (dir, dato) requests, drains one per
// cycle onto Dir/Di/RegWrite, and forwards the youngest pending value for a looked-up register.
module cola_escritura_banco #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [AW-1:0]           in_dir,
   input  logic [DW-1:0]           in_dato,
   output logic [AW-1:0]           Dir,
   output logic [DW-1:0]           Di,
   output logic                    RegWrite,
   input  logic [AW-1:0]           rd_dir,
   output logic                    rd_hit,
   output logic [DW-1:0]           rd_dato,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0] mem_dir  [DEPTH];
   logic [DW-1:0] mem_dato [DEPTH];

   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [CW-1:0] count_q, count_d;
   logic          accept;
   logic          push;
   logic          pop;
   logic [PW-1:0] idx;

   // Ready depends only on the registered occupancy, never on a same-cycle pop.
   assign in_ready = (count_q < CW'(DEPTH)) && rst_n;
   assign accept   = in_valid && in_ready;
   assign push     = accept && (in_dir != '0);
   assign pop      = (count_q != '0);
   assign count    = count_q;

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (push) begin
         wr_d = wr_q + 1'b1;
      end
      if (pop) begin
         rd_d = rd_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q     <= '0;
         rd_q     <= '0;
         count_q  <= '0;
         Dir      <= '0;
         Di       <= '0;
         RegWrite <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         if (pop) begin
            Dir      <= mem_dir[rd_q];
            Di       <= mem_dato[rd_q];
            RegWrite <= 1'b1;
         end else begin
            RegWrite <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_dir[wr_q]  <= in_dir;
         mem_dato[wr_q] <= in_dato;
      end
   end

   // Walk oldest to youngest so later matches override; the output stage has lowest priority.
   always_comb begin
      rd_hit  = 1'b0;
      rd_dato = '0;
      idx     = '0;
      if (RegWrite && (Dir == rd_dir)) begin
         rd_hit  = 1'b1;
         rd_dato = Di;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = rd_q + PW'(i);
         if ((CW'(i) < count_q) && (mem_dir[idx] == rd_dir)) begin
            rd_hit  = 1'b1;
            rd_dato = mem_dato[idx];
         end
      end
      if (rd_dir == '0) begin
         rd_hit  = 1'b0;
         rd_dato = '0;
      end
   end

endmodule

// File: tb/tb_cola_escritura_banco.sv
// Directed bench for cola_escritura_banco with a queue-based reference model checked every cycle.
module tb_cola_escritura_banco;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ready;
   logic [AW-1:0]          in_dir;
   logic [DW-1:0]          in_dato;
   logic [AW-1:0]          Dir;
   logic [DW-1:0]          Di;
   logic                   RegWrite;
   logic [AW-1:0]          rd_dir;
   logic                   rd_hit;
   logic [DW-1:0]          rd_dato;
   logic [$clog2(DEPTH):0] count;

   int checks = 0;
   int errors = 0;

   cola_escritura_banco #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_dir(in_dir), .in_dato(in_dato), .Dir(Dir), .Di(Di), .RegWrite(RegWrite),
      .rd_dir(rd_dir), .rd_hit(rd_hit), .rd_dato(rd_dato), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: pending requests in acceptance order plus the bank-port stage.
   typedef struct {
      logic [AW-1:0] d;
      logic [DW-1:0] v;
   } ent_t;

   ent_t          mq[$];
   logic [AW-1:0] m_dir = '0;
   logic [DW-1:0] m_di  = '0;
   logic          m_we  = 1'b0;
   bit            chk_en = 1'b0;
   int            cycle  = 0;

   always @(posedge clk) begin
      bit   acc;
      ent_t e;
      cycle++;
      if (!rst_n) begin
         mq.delete();
         m_we  = 1'b0;
         m_dir = '0;
         m_di  = '0;
      end else begin
         acc = in_valid && (mq.size() < DEPTH);
         if (mq.size() > 0) begin
            e     = mq.pop_front();
            m_we  = 1'b1;
            m_dir = e.d;
            m_di  = e.v;
         end else begin
            m_we = 1'b0;
         end
         if (acc && in_dir != '0) begin
            e.d = in_dir;
            e.v = in_dato;
            mq.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      logic          e_hit;
      logic [DW-1:0] e_dato;
      if (chk_en) begin
         e_hit  = 1'b0;
         e_dato = '0;
         if (rd_dir != '0) begin
            if (m_we && m_dir == rd_dir) begin
               e_hit  = 1'b1;
               e_dato = m_di;
            end
            for (int i = 0; i < mq.size(); i++) begin
               if (mq[i].d == rd_dir) begin
                  e_hit  = 1'b1;
                  e_dato = mq[i].v;
               end
            end
         end
         check("in_ready", in_ready, (mq.size() < DEPTH) && rst_n);
         check("RegWrite", RegWrite, m_we);
         check("Dir", Dir, m_dir);
         check("Di", Di, m_di);
         check("count", count, mq.size());
         check("rd_hit", rd_hit, e_hit);
         check("rd_dato", rd_dato, e_dato);
      end
   end

   // Captures bank writes during the fill/wrap sequence.
   bit            mon_en = 1'b0;
   logic [AW-1:0] seen[$];
   int            seen_cyc[$];
   int            max_count = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (RegWrite) begin
            seen.push_back(Dir);
            seen_cyc.push_back(cycle);
         end
         if (int'(count) > max_count) max_count = int'(count);
      end
   end

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_dir   = 5'd3;
      in_dato  = 32'h5555_AAAA;
      rd_dir   = '0;

      // Reset held two cycles with a pending request.
      step();
      chk_en = 1'b1;
      step();
      check("rst_ready", in_ready, 0);
      check("rst_we", RegWrite, 0);
      check("rst_dir", Dir, 0);
      check("rst_di", Di, 0);
      check("rst_count", count, 0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rel_ready", in_ready, 1);

      // Single write.
      in_valid = 1'b1;
      in_dir   = 5'd5;
      in_dato  = 32'hDEAD_BEEF;
      step();
      in_valid = 1'b0;
      check("sw_count", count, 1);
      check("sw_we0", RegWrite, 0);
      step();
      check("sw_we1", RegWrite, 1);
      check("sw_dir", Dir, 5);
      check("sw_di", Di, 32'hDEAD_BEEF);
      step();
      check("sw_we2", RegWrite, 0);
      check("sw_hold", Dir, 5);

      // Register 0 is dropped.
      in_valid = 1'b1;
      in_dir   = 5'd0;
      in_dato  = 32'h0000_1234;
      step();
      in_valid = 1'b0;
      rd_dir   = 5'd0;
      #1;
      check("z_count", count, 0);
      check("z_hit", rd_hit, 0);
      step();
      check("z_we", RegWrite, 0);

      // Back-to-back pushes through pointer wrap.
      mon_en = 1'b1;
      for (int d = 1; d <= 7; d++) begin
         in_valid = 1'b1;
         in_dir   = AW'(d);
         in_dato  = 32'h100 + d;
         step();
      end
      in_valid = 1'b0;
      repeat (3) step();
      mon_en = 1'b0;
      check("fill_n", seen.size(), 7);
      for (int i = 0; i < seen.size(); i++) begin
         check("fill_dir", seen[i], i + 1);
         check("fill_gap", seen_cyc[i], seen_cyc[0] + i);
      end
      check("fill_max", max_count, 1);

      // Forwarding priority between queued and output-stage entries.
      rd_dir   = 5'd9;
      in_valid = 1'b1;
      in_dir   = 5'd9;
      in_dato  = 32'hA;
      step();
      check("fw_a", rd_dato, 32'hA);
      in_dato = 32'hB;
      step();
      in_valid = 1'b0;
      check("fw_hit_b", rd_hit, 1);
      check("fw_b_q", rd_dato, 32'hB);
      check("fw_out_a", Di, 32'hA);
      step();
      check("fw_b_out", rd_dato, 32'hB);
      step();
      check("fw_miss", rd_hit, 0);
      check("fw_zero", rd_dato, 0);

      // Mixed traffic pattern.
      for (int i = 0; i < 40; i++) begin
         in_valid = (i % 3) != 0;
         in_dir   = AW'((i * 3) % 8);
         in_dato  = 32'hC0DE_0000 + i;
         rd_dir   = AW'(i % 8);
         step();
      end
      in_valid = 1'b0;

      // Reset in the middle of draining.
      for (int d = 1; d <= 3; d++) begin
         in_valid = 1'b1;
         in_dir   = AW'(d + 10);
         in_dato  = 32'h300 + d;
         step();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      step();
      check("mr_count", count, 0);
      check("mr_we", RegWrite, 0);
      check("mr_dir", Dir, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("mr_nowr", RegWrite, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
